// File: rtl/mc_cpu_pkg.sv
// Shared constants and types for the multi-cycle MIPS-subset control unit:
// ALU function codes, opcode/funct values, PC source codes, FSM states and
// the instruction classes produced by the decoder.
package mc_cpu_pkg;

    // ALU function codes
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_NOR  = 3'b011;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_SLLV = 3'b111;

    // Opcodes, Inst_code[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    // R-type funct values, Inst_code[5:0]
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLLV = 6'h04;

    // PC source select
    localparam logic [1:0] PCS_SEQ = 2'b00;  // PC+4
    localparam logic [1:0] PCS_BR  = 2'b01;  // PC+4+(sext imm<<2)
    localparam logic [1:0] PCS_JMP = 2'b10;  // {PC[31:28],addr26,2'b00}

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_IF     = 4'd1,
        S_ID     = 4'd2,
        S_EXE_R  = 4'd3,
        S_EXE_I  = 4'd4,
        S_EXE_MA = 4'd5,
        S_MEM_RD = 4'd6,
        S_MEM_WR = 4'd7,
        S_WB_R   = 4'd8,
        S_WB_I   = 4'd9,
        S_WB_LD  = 4'd10,
        S_BR     = 4'd11,
        S_JMP    = 4'd12,
        S_ILL    = 4'd13
    } state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_BNE,
        CLS_J,
        CLS_ILL
    } inst_class_t;

endpackage

// File: rtl/mc_cpu_decode.sv
// Combinational instruction decoder: classifies the IR contents and derives
// the ALU function, immediate extension mode and the add/sub overflow flag.
module mc_cpu_decode
    import mc_cpu_pkg::*;
(
    input  logic [31:0] Inst_code,
    output inst_class_t cls,
    output logic [2:0]  alu_op,
    output logic        imm_s,
    output logic        is_addsub
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode = Inst_code[31:26];
    assign funct  = Inst_code[5:0];
    // Register numbers and immediates only matter to the datapath.
    assign unused_fields = ^Inst_code[25:6];

    // Opcode/funct decode; unknown encodings fall through to CLS_ILL.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        cls       = CLS_ILL;
        alu_op    = ALU_ADD;
        imm_s     = 1'b0;
        is_addsub = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                cls       = CLS_R;
                is_addsub = (funct == FN_ADD) || (funct == FN_SUB);
                case (funct)
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLLV: alu_op = ALU_SLLV;
                    default: cls    = CLS_ILL;
                endcase
            end
            OP_ADDI: begin
                cls       = CLS_I;
                alu_op    = ALU_ADD;
                imm_s     = 1'b1;
                is_addsub = 1'b1;
            end
            OP_ANDI: begin
                cls    = CLS_I;
                alu_op = ALU_AND;
            end
            OP_ORI: begin
                cls    = CLS_I;
                alu_op = ALU_OR;
            end
            OP_XORI: begin
                cls    = CLS_I;
                alu_op = ALU_XOR;
            end
            OP_LW: begin
                cls   = CLS_LW;
                imm_s = 1'b1;
            end
            OP_SW: begin
                cls   = CLS_SW;
                imm_s = 1'b1;
            end
            OP_BEQ: begin
                cls    = CLS_BEQ;
                alu_op = ALU_SUB;
                imm_s  = 1'b1;
            end
            OP_BNE: begin
                cls    = CLS_BNE;
                alu_op = ALU_SUB;
                imm_s  = 1'b1;
            end
            OP_J:    cls = CLS_J;
            default: cls = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/mc_cpu_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset CPU. Sequences each instruction
// through fetch/decode/execute/memory/writeback, counts memory latencies, and
// raises one-cycle trap/illegal pulses. rst high gates every output to zero.
module mc_cpu_ctrl
    import mc_cpu_pkg::*;
#(
    parameter int IMEM_LAT = 1,
    parameter int DMEM_LAT = 1,
    parameter bit OF_TRAP  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Inst_code,
    input  logic        ZF,
    input  logic        OF,
    output logic        PC_Write,
    output logic [1:0]  PC_s,
    output logic        IR_Write,
    output logic        Write_Reg,
    output logic        Mem_Write,
    output logic        Mem_Read,
    output logic        rd_rt_s,
    output logic        imm_s,
    output logic        rt_imm_s,
    output logic        alu_mem_s,
    output logic [2:0]  ALU_OP,
    output logic        trap,
    output logic        illegal,
    output logic [3:0]  state_o
);

    localparam int MAX_LAT = (IMEM_LAT > DMEM_LAT) ? IMEM_LAT : DMEM_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] IF_LAST = CNT_W'(IMEM_LAT - 1);
    localparam logic [CNT_W-1:0] DM_LAST = CNT_W'(DMEM_LAT - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    inst_class_t dec_cls;
    logic [2:0]  dec_alu_op;
    logic        dec_imm_s;
    logic        dec_is_addsub;
    logic        ovf_trap;

    mc_cpu_decode u_decode (
        .Inst_code (Inst_code),
        .cls       (dec_cls),
        .alu_op    (dec_alu_op),
        .imm_s     (dec_imm_s),
        .is_addsub (dec_is_addsub)
    );

    assign ovf_trap = OF_TRAP && dec_is_addsub && OF;
    assign state_o  = state;

    // State register and latency counter.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; it is just the highest-priority branch on the clock edge.
        if (rst) begin
            state <= S_INIT;
            cnt   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic and Moore output decode.
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        PC_Write   = 1'b0;
        PC_s       = PCS_SEQ;
        IR_Write   = 1'b0;
        Write_Reg  = 1'b0;
        Mem_Write  = 1'b0;
        Mem_Read   = 1'b0;
        rd_rt_s    = 1'b0;
        imm_s      = 1'b0;
        rt_imm_s   = 1'b0;
        alu_mem_s  = 1'b0;
        ALU_OP     = ALU_AND;
        trap       = 1'b0;
        illegal    = 1'b0;

        case (state)
            S_INIT: state_next = S_IF;

            S_IF: begin
                if (cnt == IF_LAST) begin
                    IR_Write   = 1'b1;
                    PC_Write   = 1'b1;
                    PC_s       = PCS_SEQ;
                    state_next = S_ID;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            S_ID: begin
                case (dec_cls)
                    CLS_R:            state_next = S_EXE_R;
                    CLS_I:            state_next = S_EXE_I;
                    CLS_LW, CLS_SW:   state_next = S_EXE_MA;
                    CLS_BEQ, CLS_BNE: state_next = S_BR;
                    CLS_J:            state_next = S_JMP;
                    default:          state_next = S_ILL;
                endcase
            end

            S_EXE_R: begin
                ALU_OP     = dec_alu_op;
                state_next = S_WB_R;
            end

            S_EXE_I: begin
                ALU_OP     = dec_alu_op;
                rt_imm_s   = 1'b1;
                imm_s      = dec_imm_s;
                state_next = S_WB_I;
            end

            S_EXE_MA: begin
                ALU_OP     = ALU_ADD;
                rt_imm_s   = 1'b1;
                imm_s      = 1'b1;
                state_next = (dec_cls == CLS_LW) ? S_MEM_RD : S_MEM_WR;
            end

            // Address selects stay up so the memory sees a stable address
            // for the whole access.
            S_MEM_RD: begin
                ALU_OP   = ALU_ADD;
                rt_imm_s = 1'b1;
                imm_s    = 1'b1;
                Mem_Read = 1'b1;
                if (cnt == DM_LAST) state_next = S_WB_LD;
                else                cnt_next   = cnt + 1'b1;
            end

            S_MEM_WR: begin
                ALU_OP    = ALU_ADD;
                rt_imm_s  = 1'b1;
                imm_s     = 1'b1;
                Mem_Write = 1'b1;
                if (cnt == DM_LAST) state_next = S_IF;
                else                cnt_next   = cnt + 1'b1;
            end

            S_WB_R: begin
                ALU_OP     = dec_alu_op;
                rd_rt_s    = 1'b1;
                Write_Reg  = ~ovf_trap;
                trap       = ovf_trap;
                state_next = S_IF;
            end

            S_WB_I: begin
                ALU_OP     = dec_alu_op;
                rt_imm_s   = 1'b1;
                imm_s      = dec_imm_s;
                Write_Reg  = ~ovf_trap;
                trap       = ovf_trap;
                state_next = S_IF;
            end

            S_WB_LD: begin
                Write_Reg  = 1'b1;
                alu_mem_s  = 1'b1;
                state_next = S_IF;
            end

            S_BR: begin
                ALU_OP     = ALU_SUB;
                PC_s       = PCS_BR;
                PC_Write   = (dec_cls == CLS_BNE) ? ~ZF : ZF;
                state_next = S_IF;
            end

            S_JMP: begin
                PC_Write   = 1'b1;
                PC_s       = PCS_JMP;
                state_next = S_IF;
            end

            // PC was already advanced in IF, so the bad word is skipped.
            S_ILL: begin
                illegal    = 1'b1;
                state_next = S_IF;
            end

            default: state_next = S_INIT;
        endcase

        // An aborting reset must not let any enable through in its cycle.
        if (rst) begin
            PC_Write  = 1'b0;
            PC_s      = PCS_SEQ;
            IR_Write  = 1'b0;
            Write_Reg = 1'b0;
            Mem_Write = 1'b0;
            Mem_Read  = 1'b0;
            rd_rt_s   = 1'b0;
            imm_s     = 1'b0;
            rt_imm_s  = 1'b0;
            alu_mem_s = 1'b0;
            ALU_OP    = ALU_AND;
            trap      = 1'b0;
            illegal   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_cpu_ctrl.sv
// Scoreboard bench for mc_cpu_ctrl. Stimulus pushes the expected per-cycle
// output vector for every cycle of each instruction; a monitor pops one entry
// per cycle and compares it against two DUTs that differ only in OF_TRAP.
module tb_mc_cpu_ctrl;
    import mc_cpu_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_write;
        logic [1:0] pc_s;
        logic       ir_write;
        logic       write_reg;
        logic       mem_write;
        logic       mem_read;
        logic       rd_rt_s;
        logic       imm_s;
        logic       rt_imm_s;
        logic       alu_mem_s;
        logic [2:0] alu_op;
        logic       trap;
        logic       illegal;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Inst_code;
    logic        ZF, OF;

    logic       a_pcw, a_irw, a_wr, a_mw, a_mr, a_rdrt, a_imm, a_rtimm, a_am, a_trap, a_ill;
    logic [1:0] a_pcs;
    logic [2:0] a_alu;
    logic [3:0] a_st;
    logic       b_pcw, b_irw, b_wr, b_mw, b_mr, b_rdrt, b_imm, b_rtimm, b_am, b_trap, b_ill;
    logic [1:0] b_pcs;
    logic [2:0] b_alu;
    logic [3:0] b_st;

    obs_t obs_a, obs_b;

    obs_t  exp_q[$];
    obs_t  mask_q[$];
    bit    nt_q[$];
    string name_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    bit done  = 1'b0;

    always #5 clk = ~clk;

    mc_cpu_ctrl #(.IMEM_LAT(1), .DMEM_LAT(3), .OF_TRAP(1'b1)) dut (
        .clk(clk), .rst(rst), .Inst_code(Inst_code), .ZF(ZF), .OF(OF),
        .PC_Write(a_pcw), .PC_s(a_pcs), .IR_Write(a_irw), .Write_Reg(a_wr),
        .Mem_Write(a_mw), .Mem_Read(a_mr), .rd_rt_s(a_rdrt), .imm_s(a_imm),
        .rt_imm_s(a_rtimm), .alu_mem_s(a_am), .ALU_OP(a_alu), .trap(a_trap),
        .illegal(a_ill), .state_o(a_st)
    );

    mc_cpu_ctrl #(.IMEM_LAT(1), .DMEM_LAT(3), .OF_TRAP(1'b0)) dut_nt (
        .clk(clk), .rst(rst), .Inst_code(Inst_code), .ZF(ZF), .OF(OF),
        .PC_Write(b_pcw), .PC_s(b_pcs), .IR_Write(b_irw), .Write_Reg(b_wr),
        .Mem_Write(b_mw), .Mem_Read(b_mr), .rd_rt_s(b_rdrt), .imm_s(b_imm),
        .rt_imm_s(b_rtimm), .alu_mem_s(b_am), .ALU_OP(b_alu), .trap(b_trap),
        .illegal(b_ill), .state_o(b_st)
    );

    assign obs_a = {a_st, a_pcw, a_pcs, a_irw, a_wr, a_mw, a_mr, a_rdrt, a_imm, a_rtimm, a_am, a_alu, a_trap, a_ill};
    assign obs_b = {b_st, b_pcw, b_pcs, b_irw, b_wr, b_mw, b_mr, b_rdrt, b_imm, b_rtimm, b_am, b_alu, b_trap, b_ill};

    task automatic check(input string name, input obs_t act, input obs_t exp, input obs_t mask);
        logic [$bits(obs_t)-1:0] diff;
        diff = (act ^ exp) & mask;
        n_cmp++;
        if (diff !== '0) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (mask %h) at %0t", name, act, exp, mask, $time);
        end
    endtask

    function automatic obs_t o_st(input state_t s);
        obs_t o;
        o    = '0;
        o.st = s;
        return o;
    endfunction

    // mem_dc: address selects are don't-care; nt: trap cycle for dut only.
    task automatic push(input string nm, input obs_t e, input bit mem_dc = 1'b0, input bit nt = 1'b0);
        obs_t m;
        m = '1;
        if (mem_dc) begin
            m.alu_op   = '0;
            m.imm_s    = 1'b0;
            m.rt_imm_s = 1'b0;
        end
        exp_q.push_back(e);
        mask_q.push_back(m);
        nt_q.push_back(nt);
        name_q.push_back(nm);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_fetch(input string tag);
        obs_t e;
        e = o_st(S_IF);
        e.ir_write = 1'b1;
        e.pc_write = 1'b1;
        push({tag, ":if"}, e);
        push({tag, ":id"}, o_st(S_ID));
    endtask

    task automatic run_r(input string tag, input logic [5:0] fn, input logic [2:0] alu,
                         input logic of, input bit trap_exp);
        obs_t e;
        Inst_code = {OP_RTYPE, 5'd2, 5'd3, 5'd4, 5'd0, fn};
        OF = of;
        ZF = 1'b0;
        exp_fetch(tag);
        e = o_st(S_EXE_R); e.alu_op = alu;
        push({tag, ":exe"}, e);
        e = o_st(S_WB_R); e.alu_op = alu; e.rd_rt_s = 1'b1;
        e.write_reg = !trap_exp; e.trap = trap_exp;
        push({tag, ":wb"}, e, 1'b0, trap_exp);
        step(4);
    endtask

    task automatic run_i(input string tag, input logic [31:0] code, input logic [2:0] alu,
                         input logic imm, input logic of, input bit trap_exp);
        obs_t e;
        Inst_code = code;
        OF = of;
        ZF = 1'b1;
        exp_fetch(tag);
        e = o_st(S_EXE_I); e.alu_op = alu; e.rt_imm_s = 1'b1; e.imm_s = imm;
        push({tag, ":exe"}, e);
        e = o_st(S_WB_I); e.alu_op = alu; e.rt_imm_s = 1'b1; e.imm_s = imm;
        e.write_reg = !trap_exp; e.trap = trap_exp;
        push({tag, ":wb"}, e, 1'b0, trap_exp);
        step(4);
    endtask

    task automatic exp_ma(input string tag);
        obs_t e;
        e = o_st(S_EXE_MA); e.alu_op = ALU_ADD; e.rt_imm_s = 1'b1; e.imm_s = 1'b1;
        push({tag, ":ma"}, e);
    endtask

    task automatic run_lw(input string tag, input logic [31:0] code);
        obs_t e;
        Inst_code = code;
        OF = 1'b1;
        ZF = 1'b1;
        exp_fetch(tag);
        exp_ma(tag);
        for (int i = 0; i < 3; i++) begin
            e = o_st(S_MEM_RD); e.mem_read = 1'b1;
            push({tag, ":mrd"}, e, 1'b1);
        end
        e = o_st(S_WB_LD); e.write_reg = 1'b1; e.alu_mem_s = 1'b1;
        push({tag, ":wbld"}, e);
        step(7);
    endtask

    task automatic run_sw(input string tag, input logic [31:0] code);
        obs_t e;
        Inst_code = code;
        OF = 1'b1;
        ZF = 1'b0;
        exp_fetch(tag);
        exp_ma(tag);
        for (int i = 0; i < 3; i++) begin
            e = o_st(S_MEM_WR); e.mem_write = 1'b1;
            push({tag, ":mwr"}, e, 1'b1);
        end
        step(6);
    endtask

    task automatic run_br(input string tag, input logic [31:0] code, input logic zf, input logic taken);
        obs_t e;
        Inst_code = code;
        ZF = zf;
        OF = 1'b0;
        exp_fetch(tag);
        e = o_st(S_BR); e.alu_op = ALU_SUB; e.pc_s = PCS_BR; e.pc_write = taken;
        push({tag, ":br"}, e);
        step(3);
    endtask

    task automatic run_j(input string tag, input logic [31:0] code);
        obs_t e;
        Inst_code = code;
        ZF = 1'b0;
        OF = 1'b0;
        exp_fetch(tag);
        e = o_st(S_JMP); e.pc_write = 1'b1; e.pc_s = PCS_JMP;
        push({tag, ":jmp"}, e);
        step(3);
    endtask

    task automatic run_ill(input string tag, input logic [31:0] code);
        obs_t e;
        Inst_code = code;
        ZF = 1'b1;
        OF = 1'b1;
        exp_fetch(tag);
        e = o_st(S_ILL); e.illegal = 1'b1;
        push({tag, ":ill"}, e);
        step(3);
    endtask

    // Monitor: one expected entry per cycle, sampled mid-cycle.
    initial begin
        obs_t  e, e2, m;
        bit    nt;
        string nm;
        forever begin
            @(negedge clk);
            if (!done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL scoreboard_underflow: got empty queue expected an entry at %0t", $time);
                end else begin
                    e  = exp_q.pop_front();
                    m  = mask_q.pop_front();
                    nt = nt_q.pop_front();
                    nm = name_q.pop_front();
                    check(nm, obs_a, e, m);
                    e2 = e;
                    if (nt) begin
                        e2.write_reg = 1'b1;
                        e2.trap      = 1'b0;
                    end
                    check({nm, "/no_of_trap"}, obs_b, e2, m);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $fatal(1);
    end

    // Directed stimulus.
    initial begin
        logic [5:0] fn_tab  [8] = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLLV};
        logic [2:0] alu_tab [8] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLLV};
        bit         trap_tab[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        int         qleft;

        rst       = 1'b1;
        Inst_code = 32'h0;
        ZF        = 1'b0;
        OF        = 1'b0;
        // Two cycles with rst held, then the INIT cycle after release.
        for (int i = 0; i < 3; i++) push("reset_init", o_st(S_INIT));
        step(3);
        rst = 1'b0;
        step(1);

        // add 0x00432020 without overflow
        Inst_code = 32'h00432020;
        run_r("add", FN_ADD, ALU_ADD, 1'b0, 1'b0);

        // every R op with OF=1: only add/sub trap
        for (int i = 0; i < 8; i++)
            run_r($sformatf("r_of_fn%02h", fn_tab[i]), fn_tab[i], alu_tab[i], 1'b1, trap_tab[i]);

        run_i("addi_of", 32'h20410005, ALU_ADD, 1'b1, 1'b1, 1'b1);
        run_i("addi",    32'h20410005, ALU_ADD, 1'b1, 1'b0, 1'b0);
        run_i("ori_of",  32'h34410005, ALU_OR,  1'b0, 1'b1, 1'b0);
        run_i("andi",    32'h30410005, ALU_AND, 1'b0, 1'b0, 1'b0);
        run_i("xori_of", 32'h38410005, ALU_XOR, 1'b0, 1'b1, 1'b0);

        run_lw("lw", 32'h8C220004);
        run_sw("sw", 32'hAC220004);

        run_br("beq_z1", 32'h10220003, 1'b1, 1'b1);
        run_br("beq_z0", 32'h10220003, 1'b0, 1'b0);
        run_br("bne_z0", 32'h14220003, 1'b0, 1'b1);
        run_br("bne_z1", 32'h14220003, 1'b1, 1'b0);

        run_j("j", 32'h08000010);
        run_ill("ill_op", 32'hFC000000);
        run_ill("ill_fn", 32'h0043203F);

        // sw aborted by reset in the second MEM_WR cycle
        begin
            obs_t e;
            Inst_code = 32'hAC220004;
            OF = 1'b0;
            ZF = 1'b0;
            exp_fetch("abort");
            exp_ma("abort");
            e = o_st(S_MEM_WR); e.mem_write = 1'b1;
            push("abort:mwr1", e, 1'b1);
            step(4);
            rst = 1'b1;
            push("abort:mwr2_rst", o_st(S_MEM_WR));
            step(1);
            rst = 1'b0;
            push("abort:init", o_st(S_INIT));
            step(1);
        end

        // counter must restart cleanly after the abort
        run_lw("lw_after_abort", 32'h8C220004);
        Inst_code = 32'h00432020;
        run_r("add_last", FN_ADD, ALU_ADD, 1'b0, 1'b0);

        done  = 1'b1;
        qleft = exp_q.size();
        n_cmp++;
        if (qleft != 0) begin
            n_bad++;
            $display("FAIL queue_drained: got %0d entries left expected 0", qleft);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
